mips_multicycle: RTL and testbench
==================================

# mips_multicycle

Parametrised multi-cycle successor to the 16-bit single-cycle MIPS core. It executes the same 16-bit instruction encoding with a DATA_W-wide datapath. It fetches and accesses data through one shared memory port with a request/ready handshake, so it tolerates wait states. A FETCH/DECODE/EXEC/MEM/WB state machine sequences each instruction, and an explicit halt state stops execution.

## Interface
- DATA_W, 16: datapath, register, PC and memory-address width; legal values ≥16.
- RESET_PC, 0: PC value loaded on reset; must be even.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- mem_req  out  1  memory request, held high until accepted
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high
- mem_addr  out  DATA_W  byte address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid in the cycle mem_ready is high
- mem_ready  in  1  access complete; sampled at the clock edge where mem_req is high
- pc_out  out  DATA_W  current PC register
- alu_result  out  DATA_W  registered ALU output
- halted  out  1  core stopped
- instr_count  out  32  retired instructions (only with MIPS_MC_PERF_EN)

## Operation
- Field layout: op [15:13], rs [12:10], rt [9:7], rd [6:4], funct [3:0], imm [6:0], jtarget [12:0].
- Immediate: imm is sign-extended to DATA_W.
- Register file: 8 × DATA_W. r0 always reads 0 and ignores writes. Two read ports and one write port; a write takes effect at the clock edge.
- Opcodes:
  - 000 R-type, by funct: 0 add, 1 sub, 2 and, 3 or, 4 slt (signed, result 1 or 0), 8 jr. Any other funct is a NOP that retires.
  - 001 addi: rt = rs + imm.
  - 010 lw: rt = M[rs + imm].
  - 011 sw: M[rs + imm] = rt.
  - 100 beq: if rs == rt, pc = pc + 2 + (imm << 1).
  - 101 j: pc = {pc+2[DATA_W-1:14], jtarget, 0}.
  - 110 jal: r7 = pc + 2, then jump as j.
  - 111 halt.
- Arithmetic wraps modulo 2^DATA_W. No overflow traps.
- State machine:
  - FETCH: drive mem_req=1, mem_we=0, mem_addr=pc. On mem_ready, latch IR and set pc <= pc + 2, then go to DECODE.
  - DECODE: latch A = R[rs] and B = R[rt]. Halt goes to HALT; all other opcodes go to EXEC.
  - EXEC, by opcode:
    - R-type and addi: latch the ALU result, then go to WB.
    - lw and sw: compute the address, then go to MEM.
    - beq: compare A and B and update pc if equal, then go to FETCH.
    - j, jal, jr: update pc (jal also writes r7), then go to FETCH.
  - MEM: drive mem_addr = alu_result. For sw, mem_we=1 and mem_wdata=B. Hold until mem_ready. sw then goes to FETCH; lw latches mem_rdata and goes to WB.
  - WB: write the register file, then go to FETCH.
  - HALT: absorbing state; left only by reset.
- Retirement: an instruction retires when it leaves EXEC (beq, j, jal, jr), leaves MEM (sw), leaves WB, or enters HALT.

## Timing
- Reset values: pc_out = RESET_PC; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; alu_result=0; halted=0; instr_count=0; all registers 0; state = FETCH.
- Reset asserted mid-access drops mem_req asynchronously. The memory must discard that access.
- Cycles per instruction with zero-wait memory (mem_ready high in the request cycle): beq, j, jal, jr = 3; R-type, addi, sw = 4; lw = 5.
- Each wait cycle (mem_ready low) adds 1 cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req is high.
- mem_req is low in DECODE, EXEC, WB and HALT.
- halted rises the cycle after DECODE of a halt instruction.
- A jr to an odd address clears bit 0.

## Configuration
- MIPS_MC_PERF_EN defined: the instr_count port exists and increments by 1 per retired instruction, wrapping at 2^32.
- MIPS_MC_PERF_EN undefined: the instr_count port and counter are absent; all other behaviour is identical.

## Structure
- Package mips_mc_pkg holds:
  - opcode and funct constants;
  - the state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - ALU control codes.
- Sub-module mips_mc_alu: combinational, parametrised by DATA_W, inputs a, b and ctrl, outputs result and zero.
- The register file, FSM and datapath stay in mips_multicycle.

## Test plan
- Reset with RESET_PC=0x0010, then release: first mem_req has addr 0x0010; pc_out=0x0010 during reset.
- addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sw r3,0(r0); halt, all zero-wait: write of 0x0002 to address 0; halted=1; instr_count=5.
- The same program with 2 wait cycles on every access: identical results; the total cycle count rises by 2 × 6 accesses (5 fetches + 1 store).
- beq r0,r0,-1 at address 0x0020: pc returns to 0x0020 every 3 cycles.
- jal to jtarget 0x0040, then jr r7: r7 = old pc + 2, and the return lands there; writes to r0 leave it reading 0.
- DATA_W=32 run of slt on 0x80000000 vs 1: result 1; assert reset mid-MEM: mem_req drops to 0 immediately.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared constants and types for the multi-cycle MIPS core.
// Holds the instruction field codes, the FSM state enum and the ALU control codes.
package mips_mc_pkg;

  // Major opcodes, instruction bits [15:13]
  localparam logic [2:0] OP_RTYPE = 3'b000;
  localparam logic [2:0] OP_ADDI  = 3'b001;
  localparam logic [2:0] OP_LW    = 3'b010;
  localparam logic [2:0] OP_SW    = 3'b011;
  localparam logic [2:0] OP_BEQ   = 3'b100;
  localparam logic [2:0] OP_J     = 3'b101;
  localparam logic [2:0] OP_JAL   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // R-type function codes, instruction bits [3:0]
  localparam logic [3:0] FN_ADD = 4'd0;
  localparam logic [3:0] FN_SUB = 4'd1;
  localparam logic [3:0] FN_AND = 4'd2;
  localparam logic [3:0] FN_OR  = 4'd3;
  localparam logic [3:0] FN_SLT = 4'd4;
  localparam logic [3:0] FN_JR  = 4'd8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_ctrl_t;

  // Map an R-type funct onto an ALU operation; non-ALU functs fall back to add
  function automatic alu_ctrl_t funct_to_alu(input logic [3:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// mips_mc_alu: combinational DATA_W-wide ALU (add, sub, and, or, signed slt).
module mips_mc_alu
  import mips_mc_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_ctrl_t         ctrl,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Select the operation; arithmetic wraps, slt compares as signed values
  always_comb begin
    result = '0;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mips_multicycle.sv
// mips_multicycle: multi-cycle core for the 16-bit MIPS encoding with a DATA_W datapath
// and one shared request/ready memory port. Defining MIPS_MC_PERF_EN adds the
// instr_count output, a wrapping count of retired instructions.
module mips_multicycle
  import mips_mc_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] alu_result,
  output logic              halted
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [31:0]       instr_count
`endif
);

  state_t            r_state;
  logic [DATA_W-1:0] r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_a, r_b, r_alu_result, r_mdr;
  logic [DATA_W-1:0] r_regs [0:7];
  logic              r_mem_req, r_mem_we, r_halted;
  logic [DATA_W-1:0] r_mem_addr, r_mem_wdata;

  logic [2:0]        w_op, w_rs, w_rt, w_rd, w_rf_waddr;
  logic [3:0]        w_funct;
  logic [DATA_W-1:0] w_imm_ext, w_rs_data, w_rt_data, w_alu_b, w_alu_y;
  logic [DATA_W-1:0] w_branch_target, w_jump_target, w_exec_next_pc, w_rf_wdata;
  logic              w_alu_zero, w_is_jr, w_exec_to_fetch, w_exec_to_mem, w_rf_we;
  alu_ctrl_t         w_alu_ctrl;

  assign w_op      = r_ir[15:13];
  assign w_rs      = r_ir[12:10];
  assign w_rt      = r_ir[9:7];
  assign w_rd      = r_ir[6:4];
  assign w_funct   = r_ir[3:0];
  assign w_imm_ext = {{(DATA_W-7){r_ir[6]}}, r_ir[6:0]};
  assign w_rs_data = (w_rs == 3'd0) ? '0 : r_regs[w_rs];
  assign w_rt_data = (w_rt == 3'd0) ? '0 : r_regs[w_rt];

  // beq reuses the ALU as a subtractor so its zero flag is the equality test
  assign w_is_jr    = (w_op == OP_RTYPE) && (w_funct == FN_JR);
  assign w_alu_b    = (w_op == OP_RTYPE || w_op == OP_BEQ) ? r_b : w_imm_ext;
  assign w_alu_ctrl = (w_op == OP_RTYPE) ? funct_to_alu(w_funct) :
                      (w_op == OP_BEQ)   ? ALU_SUB : ALU_ADD;

  mips_mc_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (r_a),
    .b      (w_alu_b),
    .ctrl   (w_alu_ctrl),
    .result (w_alu_y),
    .zero   (w_alu_zero)
  );

  // r_pc already holds pc+2 once the instruction has been fetched
  assign w_branch_target = r_pc + {w_imm_ext[DATA_W-2:0], 1'b0};
  assign w_jump_target   = {r_pc[DATA_W-1:14], r_ir[12:0], 1'b0};
  assign w_exec_to_fetch = (w_op == OP_BEQ) || (w_op == OP_J) || (w_op == OP_JAL) || w_is_jr;
  assign w_exec_to_mem   = (w_op == OP_LW) || (w_op == OP_SW);

  // Next PC for control-flow instructions leaving EXEC; jr forces an even target
  always_comb begin
    w_exec_next_pc = r_pc;
    case (w_op)
      OP_BEQ:       w_exec_next_pc = w_alu_zero ? w_branch_target : r_pc;
      OP_J, OP_JAL: w_exec_next_pc = w_jump_target;
      default:      w_exec_next_pc = w_is_jr ? {r_a[DATA_W-1:1], 1'b0} : r_pc;
    endcase
  end

  // Single register-file write port shared by WB and the jal link in EXEC
  always_comb begin
    w_rf_we    = 1'b0;
    w_rf_waddr = 3'd0;
    w_rf_wdata = '0;
    if (r_state == ST_WB) begin
      case (w_op)
        OP_RTYPE: begin
          w_rf_we    = (w_funct <= FN_SLT);
          w_rf_waddr = w_rd;
          w_rf_wdata = r_alu_result;
        end
        OP_ADDI: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_rt;
          w_rf_wdata = r_alu_result;
        end
        OP_LW: begin
          w_rf_we    = 1'b1;
          w_rf_waddr = w_rt;
          w_rf_wdata = r_mdr;
        end
        default: w_rf_we = 1'b0;
      endcase
    end else if (r_state == ST_EXEC && w_op == OP_JAL) begin
      w_rf_we    = 1'b1;
      w_rf_waddr = 3'd7;
      w_rf_wdata = r_pc;
    end
  end

  // Register file; r0 is never written so it always reads zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else if (w_rf_we && w_rf_waddr != 3'd0) begin
      r_regs[w_rf_waddr] <= w_rf_wdata;
    end
  end

  // Instruction sequencer; memory outputs are registered and raised on entry to FETCH/MEM
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_FETCH;
      r_pc         <= RESET_PC;
      r_ir         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_alu_result <= '0;
      r_mdr        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (r_mem_req && mem_ready) begin
            r_ir      <= mem_rdata[15:0];
            r_pc      <= r_pc + DATA_W'(2);
            r_mem_req <= 1'b0;
            r_state   <= ST_DECODE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        ST_DECODE: begin
          r_a <= w_rs_data;
          r_b <= w_rt_data;
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= ST_HALT;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_alu_result <= w_alu_y;
          if (w_exec_to_fetch) begin
            r_pc       <= w_exec_next_pc;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_exec_next_pc;
            r_state    <= ST_FETCH;
          end else if (w_exec_to_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_SW);
            r_mem_addr  <= w_alu_y;
            r_mem_wdata <= r_b;
            r_state     <= ST_MEM;
          end else begin
            r_state <= ST_WB;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            r_mem_we <= 1'b0;
            if (w_op == OP_SW) begin
              r_mem_req  <= 1'b1;
              r_mem_addr <= r_pc;
              r_state    <= ST_FETCH;
            end else begin
              r_mdr     <= mem_rdata;
              r_mem_req <= 1'b0;
              r_state   <= ST_WB;
            end
          end
        end
        ST_WB: begin
          r_mem_req  <= 1'b1;
          r_mem_we   <= 1'b0;
          r_mem_addr <= r_pc;
          r_state    <= ST_FETCH;
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign pc_out     = r_pc;
  assign alu_result = r_alu_result;
  assign halted     = r_halted;

`ifdef MIPS_MC_PERF_EN
  logic [31:0] r_instr_count;
  logic        w_retire;

  assign w_retire = ((r_state == ST_EXEC) && w_exec_to_fetch) ||
                    ((r_state == ST_MEM) && mem_ready && (w_op == OP_SW)) ||
                    (r_state == ST_WB) ||
                    ((r_state == ST_DECODE) && (w_op == OP_HALT));

  // Retirement counter, wraps at 2^32
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'd1;
  end

  assign instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed tests for mips_multicycle (16-bit and 32-bit instances),
// each with a behavioural memory offering configurable wait states.
module tb_mips_multicycle;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [15:0] HALT_W = 16'hE000;

  // 16-bit instance
  logic        rst16_n = 1'b0;
  logic        m16_req, m16_we, m16_ready, halted16;
  logic [15:0] m16_addr, m16_wdata, m16_rdata, pc16, alu16;
  logic [15:0] mem16 [0:255];
  int          wait16 = 0, wcnt16 = 0;
  logic [15:0] st16_addr [0:63];
  logic [15:0] st16_data [0:63];
  int          st16_n = 0;
  logic [15:0] f16_addr [0:255];
  int          f16_cyc [0:255];
  int          f16_n = 0;
`ifdef MIPS_MC_PERF_EN
  logic [31:0] cnt16, cnt32;
`endif

  // 32-bit instance
  logic        rst32_n = 1'b0;
  logic        m32_req, m32_we, m32_ready, halted32;
  logic [31:0] m32_addr, m32_wdata, m32_rdata, pc32, alu32;
  logic [31:0] mem32 [0:255];
  int          wait32 = 0, wcnt32 = 0;
  logic        hold_wr32 = 1'b0;
  logic [31:0] st32_addr [0:63];
  logic [31:0] st32_data [0:63];
  int          st32_n = 0;

  mips_multicycle #(.DATA_W(16), .RESET_PC(16'h0010)) dut16 (
    .clk(clk), .reset(rst16_n), .mem_req(m16_req), .mem_we(m16_we), .mem_addr(m16_addr),
    .mem_wdata(m16_wdata), .mem_rdata(m16_rdata), .mem_ready(m16_ready), .pc_out(pc16),
    .alu_result(alu16), .halted(halted16)
`ifdef MIPS_MC_PERF_EN
    , .instr_count(cnt16)
`endif
  );

  mips_multicycle #(.DATA_W(32), .RESET_PC(32'h0)) dut32 (
    .clk(clk), .reset(rst32_n), .mem_req(m32_req), .mem_we(m32_we), .mem_addr(m32_addr),
    .mem_wdata(m32_wdata), .mem_rdata(m32_rdata), .mem_ready(m32_ready), .pc_out(pc32),
    .alu_result(alu32), .halted(halted32)
`ifdef MIPS_MC_PERF_EN
    , .instr_count(cnt32)
`endif
  );

  // Memory models: one entry per halfword address, ready after wait cycles
  assign m16_rdata = mem16[m16_addr[8:1]];
  assign m16_ready = m16_req && (wcnt16 >= wait16);
  assign m32_rdata = mem32[m32_addr[8:1]];
  assign m32_ready = m32_req && !(hold_wr32 && m32_we) && (wcnt32 >= wait32);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!m16_req || m16_ready) wcnt16 <= 0; else wcnt16 <= wcnt16 + 1;
    if (!m32_req || m32_ready) wcnt32 <= 0; else wcnt32 <= wcnt32 + 1;
    if (m16_req && m16_ready) begin
      if (m16_we) begin
        if (st16_n < 64) begin
          st16_addr[st16_n] <= m16_addr;
          st16_data[st16_n] <= m16_wdata;
        end
        st16_n <= st16_n + 1;
        $display("[TB] dut16 store addr=%h data=%h", m16_addr, m16_wdata);
      end else begin
        if (f16_n < 256) begin
          f16_addr[f16_n] <= m16_addr;
          f16_cyc[f16_n]  <= cyc;
        end
        f16_n <= f16_n + 1;
      end
    end
    if (m32_req && m32_ready && m32_we) begin
      if (st32_n < 64) begin
        st32_addr[st32_n] <= m32_addr;
        st32_data[st32_n] <= m32_wdata;
      end
      st32_n <= st32_n + 1;
      $display("[TB] dut32 store addr=%h data=%h", m32_addr, m32_wdata);
    end
  end

  function automatic logic [15:0] enc_r(input int rs, input int rt, input int rd, input logic [3:0] fn);
    return {OP_RTYPE, 3'(rs), 3'(rt), 3'(rd), fn};
  endfunction
  function automatic logic [15:0] enc_i(input logic [2:0] op, input int rs, input int rt, input int imm);
    return {op, 3'(rs), 3'(rt), 7'(imm)};
  endfunction
  function automatic logic [15:0] enc_j(input logic [2:0] op, input int target);
    return {op, 13'(target)};
  endfunction

  task automatic clear16();
    for (int i = 0; i < 256; i++) mem16[i] = HALT_W;
  endtask
  task automatic put16(input logic [15:0] a, input logic [15:0] w);
    mem16[a[8:1]] = w;
  endtask
  task automatic clear32();
    for (int i = 0; i < 256; i++) mem32[i] = {16'h0, HALT_W};
  endtask
  task automatic put32(input logic [31:0] a, input logic [31:0] w);
    mem32[a[8:1]] = w;
  endtask

  task automatic restart16(input int w);
    rst16_n = 1'b0;
    wait16  = w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst16_n = 1'b1;
  endtask
  task automatic restart32(input int w);
    rst32_n = 1'b0;
    wait32  = w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst32_n = 1'b1;
  endtask

  // Count clock edges after reset release until halted (max+1 on timeout)
  task automatic run16(input int max, output int cycles);
    cycles = max + 1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk); #1;
      if (halted16) begin cycles = c; break; end
    end
  endtask
  task automatic run32(input int max, output int cycles);
    cycles = max + 1;
    for (int c = 1; c <= max; c++) begin
      @(posedge clk); #1;
      if (halted32) begin cycles = c; break; end
    end
  endtask

  task automatic load_prog1();
    logic [15:0] p [5];
    p = '{enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_ADDI, 0, 2, -3), enc_r(1, 2, 3, FN_ADD),
          enc_i(OP_SW, 0, 3, 0), HALT_W};
    clear16();
    for (int i = 0; i < 5; i++) put16(16'(16'h10 + 2 * i), p[i]);
  endtask

  task automatic test_reset();
    bit found;
    load_prog1();
    rst16_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (pc16 !== 16'h0010) begin n_fail++; $display("FAIL reset_pc: got %h expected 0010", pc16); end
    n_tests++; if (m16_req !== 1'b0 || m16_we !== 1'b0) begin n_fail++; $display("FAIL reset_req_we: got %b%b expected 00", m16_req, m16_we); end
    n_tests++; if (m16_addr !== 16'h0 || m16_wdata !== 16'h0) begin n_fail++; $display("FAIL reset_addr_wdata: got %h/%h expected 0000/0000", m16_addr, m16_wdata); end
    n_tests++; if (alu16 !== 16'h0 || halted16 !== 1'b0) begin n_fail++; $display("FAIL reset_alu_halted: got %h/%b expected 0000/0", alu16, halted16); end
`ifdef MIPS_MC_PERF_EN
    n_tests++; if (cnt16 !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", cnt16); end
`endif
    @(negedge clk);
    rst16_n = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(posedge clk); #1;
      if (m16_req) found = 1'b1;
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL first_req: got no request expected request"); end
    n_tests++; if (m16_addr !== 16'h0010 || m16_we !== 1'b0) begin n_fail++; $display("FAIL first_addr: got %h we=%b expected 0010 we=0", m16_addr, m16_we); end
  endtask

  task automatic test_prog1();
    int c0, c2, sb;
    load_prog1();
    sb = st16_n;
    restart16(0);
    run16(200, c0);
    n_tests++; if (halted16 !== 1'b1) begin n_fail++; $display("FAIL p1_halted: got %b expected 1", halted16); end
    n_tests++; if (c0 != 19) begin n_fail++; $display("FAIL p1_cycles: got %0d expected 19", c0); end
    n_tests++; if (st16_n - sb != 1 || st16_addr[sb] !== 16'h0 || st16_data[sb] !== 16'h0002) begin
      n_fail++; $display("FAIL p1_store: got n=%0d addr=%h data=%h expected n=1 addr=0000 data=0002", st16_n - sb, st16_addr[sb], st16_data[sb]); end
`ifdef MIPS_MC_PERF_EN
    n_tests++; if (cnt16 !== 32'd5) begin n_fail++; $display("FAIL p1_count: got %0d expected 5", cnt16); end
`endif
    sb = st16_n;
    restart16(2);
    run16(300, c2);
    n_tests++; if (halted16 !== 1'b1) begin n_fail++; $display("FAIL p1w_halted: got %b expected 1", halted16); end
    n_tests++; if (c2 - c0 != 12) begin n_fail++; $display("FAIL p1w_extra_cycles: got %0d expected 12", c2 - c0); end
    n_tests++; if (st16_n - sb != 1 || st16_addr[sb] !== 16'h0 || st16_data[sb] !== 16'h0002) begin
      n_fail++; $display("FAIL p1w_store: got n=%0d addr=%h data=%h expected n=1 addr=0000 data=0002", st16_n - sb, st16_addr[sb], st16_data[sb]); end
`ifdef MIPS_MC_PERF_EN
    n_tests++; if (cnt16 !== 32'd5) begin n_fail++; $display("FAIL p1w_count: got %0d expected 5", cnt16); end
`endif
  endtask

  task automatic test_alu_ops();
    logic [15:0] p [17];
    logic [15:0] ea [7];
    logic [15:0] ed [7];
    int c, sb;
    p = '{enc_i(OP_ADDI, 0, 1, 5), enc_i(OP_ADDI, 0, 2, -3),
          enc_r(1, 2, 3, FN_SUB), enc_i(OP_SW, 0, 3, 0),
          enc_r(1, 2, 3, FN_AND), enc_i(OP_SW, 0, 3, 2),
          enc_r(1, 2, 3, FN_OR),  enc_i(OP_SW, 0, 3, 4),
          enc_r(2, 1, 3, FN_SLT), enc_i(OP_SW, 0, 3, 6),
          enc_r(1, 2, 3, FN_SLT), enc_i(OP_SW, 0, 3, 8),
          enc_r(1, 2, 3, 4'd5),   enc_i(OP_SW, 0, 3, 12),
          enc_i(OP_BEQ, 1, 2, 3), enc_i(OP_SW, 0, 1, 10), HALT_W};
    ea = '{16'h0, 16'h2, 16'h4, 16'h6, 16'h8, 16'hC, 16'hA};
    ed = '{16'h0008, 16'h0005, 16'hFFFD, 16'h0001, 16'h0000, 16'h0000, 16'h0005};
    clear16();
    for (int i = 0; i < 17; i++) put16(16'(16'h10 + 2 * i), p[i]);
    sb = st16_n;
    restart16(0);
    run16(400, c);
    n_tests++; if (halted16 !== 1'b1 || st16_n - sb != 7) begin n_fail++; $display("FAIL alu_stores: got halted=%b n=%0d expected halted=1 n=7", halted16, st16_n - sb); end
    for (int i = 0; i < 7; i++) begin
      n_tests++;
      if (st16_addr[sb + i] !== ea[i] || st16_data[sb + i] !== ed[i]) begin
        n_fail++; $display("FAIL alu_store%0d: got %h@%h expected %h@%h", i, st16_data[sb + i], st16_addr[sb + i], ed[i], ea[i]);
      end
    end
`ifdef MIPS_MC_PERF_EN
    n_tests++; if (cnt16 !== 32'd17) begin n_fail++; $display("FAIL alu_count: got %0d expected 17", cnt16); end
`endif
  endtask

  task automatic test_branch_loop();
    int fb;
    clear16();
    put16(16'h10, enc_j(OP_J, 16'h0010));
    put16(16'h20, enc_i(OP_BEQ, 0, 0, -1));
    fb = f16_n;
    restart16(0);
    repeat (25) @(posedge clk);
    #1;
    n_tests++; if (f16_n - fb < 7 || f16_addr[fb] !== 16'h0010) begin n_fail++; $display("FAIL loop_start: got n=%0d first=%h expected n>=7 first=0010", f16_n - fb, f16_addr[fb]); end
    for (int k = 1; k < 7; k++) begin
      n_tests++;
      if (f16_addr[fb + k] !== 16'h0020 || f16_cyc[fb + k] - f16_cyc[fb + k - 1] != 3) begin
        n_fail++; $display("FAIL loop_fetch%0d: got addr=%h gap=%0d expected addr=0020 gap=3", k, f16_addr[fb + k], f16_cyc[fb + k] - f16_cyc[fb + k - 1]);
      end
    end
    n_tests++; if (halted16 !== 1'b0) begin n_fail++; $display("FAIL loop_halted: got %b expected 0", halted16); end
  endtask

  task automatic test_jal_jr();
    logic [15:0] ef [6];
    int c, sb, fb;
    ef = '{16'h10, 16'h80, 16'h12, 16'h14, 16'h16, 16'h18};
    clear16();
    put16(16'h10, enc_j(OP_JAL, 16'h0040));
    put16(16'h80, enc_r(7, 0, 0, FN_JR));
    put16(16'h12, enc_i(OP_ADDI, 0, 0, 7));
    put16(16'h14, enc_i(OP_SW, 0, 7, 2));
    put16(16'h16, enc_i(OP_SW, 0, 0, 4));
    sb = st16_n;
    fb = f16_n;
    restart16(1);
    run16(200, c);
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (f16_addr[fb + k] !== ef[k]) begin n_fail++; $display("FAIL jal_fetch%0d: got %h expected %h", k, f16_addr[fb + k], ef[k]); end
    end
    n_tests++; if (st16_n - sb != 2 || st16_addr[sb] !== 16'h2 || st16_data[sb] !== 16'h0012) begin
      n_fail++; $display("FAIL jal_link: got n=%0d %h@%h expected n=2 0012@0002", st16_n - sb, st16_data[sb], st16_addr[sb]); end
    n_tests++; if (st16_addr[sb + 1] !== 16'h4 || st16_data[sb + 1] !== 16'h0) begin
      n_fail++; $display("FAIL r0_zero: got %h@%h expected 0000@0004", st16_data[sb + 1], st16_addr[sb + 1]); end
`ifdef MIPS_MC_PERF_EN
    n_tests++; if (cnt16 !== 32'd6) begin n_fail++; $display("FAIL jal_count: got %0d expected 6", cnt16); end
`endif
  endtask

  task automatic test_lw_jr_odd();
    logic [15:0] ef [6];
    int c, sb, fb;
    ef = '{16'h10, 16'h12, 16'h1C, 16'h30, 16'h1E, 16'h20};
    clear16();
    put16(16'h10, enc_i(OP_ADDI, 0, 6, 16'h1D));
    put16(16'h12, enc_r(6, 0, 0, FN_JR));
    put16(16'h1C, enc_i(OP_LW, 0, 4, 16'h30));
    put16(16'h1E, enc_i(OP_SW, 0, 4, 16'h32));
    put16(16'h30, 16'hBEEF);
    sb = st16_n;
    fb = f16_n;
    restart16(0);
    run16(200, c);
    for (int k = 0; k < 6; k++) begin
      n_tests++;
      if (f16_addr[fb + k] !== ef[k]) begin n_fail++; $display("FAIL lw_read%0d: got %h expected %h", k, f16_addr[fb + k], ef[k]); end
    end
    n_tests++; if (st16_n - sb != 1 || st16_addr[sb] !== 16'h32 || st16_data[sb] !== 16'hBEEF) begin
      n_fail++; $display("FAIL lw_store: got n=%0d %h@%h expected n=1 beef@0032", st16_n - sb, st16_data[sb], st16_addr[sb]); end
  endtask

  task automatic test_slt32();
    int c, sb;
    clear32();
    put32(32'h0, {16'h0, enc_i(OP_LW, 0, 1, 16'h30)});
    put32(32'h2, {16'h0, enc_i(OP_ADDI, 0, 2, 1)});
    put32(32'h4, {16'h0, enc_r(1, 2, 3, FN_SLT)});
    put32(32'h6, {16'h0, enc_i(OP_SW, 0, 3, 16'h20)});
    put32(32'h30, 32'h8000_0000);
    sb = st32_n;
    restart32(0);
    run32(200, c);
    n_tests++; if (halted32 !== 1'b1) begin n_fail++; $display("FAIL slt32_halted: got %b expected 1", halted32); end
    n_tests++; if (st32_n - sb != 1 || st32_addr[sb] !== 32'h20 || st32_data[sb] !== 32'h1) begin
      n_fail++; $display("FAIL slt32_store: got n=%0d %h@%h expected n=1 00000001@00000020", st32_n - sb, st32_data[sb], st32_addr[sb]); end
    n_tests++; if (alu32 !== 32'h20) begin n_fail++; $display("FAIL slt32_alu: got %h expected 00000020", alu32); end
  endtask

  task automatic test_reset_mid_mem();
    bit found;
    int sb;
    clear32();
    put32(32'h0, {16'h0, enc_i(OP_SW, 0, 0, 16'h20)});
    hold_wr32 = 1'b1;
    sb = st32_n;
    restart32(0);
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(posedge clk); #1;
      if (m32_req && m32_we) found = 1'b1;
    end
    n_tests++; if (!found || m32_addr !== 32'h20) begin n_fail++; $display("FAIL midmem_reach: got found=%b addr=%h expected found=1 addr=00000020", found, m32_addr); end
    @(negedge clk);
    rst32_n = 1'b0;
    #1;
    n_tests++; if (m32_req !== 1'b0 || m32_we !== 1'b0) begin n_fail++; $display("FAIL midmem_drop: got req=%b we=%b expected 0 0", m32_req, m32_we); end
    n_tests++; if (pc32 !== 32'h0) begin n_fail++; $display("FAIL midmem_pc: got %h expected 00000000", pc32); end
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (st32_n != sb) begin n_fail++; $display("FAIL midmem_nostore: got %0d stores expected 0", st32_n - sb); end
    hold_wr32 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_prog1();
    test_alu_ops();
    test_branch_loop();
    test_jal_jr();
    test_lw_jr_odd();
    test_slt32();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
